// File: rtl/add_rc_pkg.sv
// ---------------------------------------------------------------------------
// add_rc_pkg
//   Shared constants and types for the serial add-round-constant sequencer.
//   LANES/DEPTH set the inner/outer counter moduli, ROUNDS the number of
//   legal round indices, RW the round index width. LANE_W/SLICE_W are the
//   widths of the lane and slice address buses.
// ---------------------------------------------------------------------------
package add_rc_pkg;

  localparam int LANES   = 25;
  localparam int DEPTH   = 64;
  localparam int ROUNDS  = 24;
  localparam int RW      = 5;
  localparam int LANE_W  = $clog2(LANES);  // 5
  localparam int SLICE_W = $clog2(DEPTH);  // 6

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A round index is usable only if the RC ROM has an entry for it.
  function automatic logic round_valid(input logic [RW-1:0] r);
    return r < RW'(ROUNDS);
  endfunction

endpackage

// File: rtl/add_rc_mod_counter.sv
// ---------------------------------------------------------------------------
// add_rc_mod_counter
//   Modulo-N up counter with synchronous clear and a terminal-count flag.
//   The modulus comes from N, not from the natural width W, so a 5-bit
//   counter with N=25 wraps 24 -> 0.
//
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-low reset (count -> 0)
//   clr    in   synchronous clear, has priority over inc
//   inc    in   advance by one (wrapping at N-1)
//   count  out  current value, 0..N-1
//   co     out  count == N-1 (ungated terminal count)
// ---------------------------------------------------------------------------
module add_rc_mod_counter #(
  parameter int N = 25,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         co
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign co = (count == LAST);

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= co ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/add_rc_controller.sv
// ---------------------------------------------------------------------------
// add_rc_controller
//   Sequencer for the serial addRc stage. A start pulse with a legal round
//   index walks the 25-lane x 64-slice state one bit per accepted transfer,
//   lane inner and slice outer. An illegal round index is rejected with a
//   one-cycle err pulse. After the final bit the controller spends one cycle
//   in DONE (done pulse) before returning to IDLE.
//
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   start     in   request to process one round (honoured only in IDLE)
//   round_in  in   round index sampled with start
//   ready     in   downstream accepts a bit this cycle
//   en        out  bit transfer this cycle (RUN & ready)
//   lane      out  current lane index 0..LANES-1
//   slice     out  current slice index 0..DEPTH-1
//   co_c25    out  last lane of a slice, RUN only
//   co_c64    out  last slice, RUN only
//   apply_rc  out  lane 0 of a slice, RUN only: bit receives the RC XOR
//   round     out  latched round index for the RC ROM
//   busy      out  RUN or DONE
//   done      out  one-cycle pulse after the final bit
//   err       out  one-cycle pulse after a rejected start
// ---------------------------------------------------------------------------
module add_rc_controller
  import add_rc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [RW-1:0]      round_in,
  input  logic               ready,
  output logic               en,
  output logic [LANE_W-1:0]  lane,
  output logic [SLICE_W-1:0] slice,
  output logic               co_c25,
  output logic               co_c64,
  output logic               apply_rc,
  output logic [RW-1:0]      round,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t state;
  logic   accept;
  logic   reject;
  logic   lane_co;
  logic   slice_co;
  logic   last_bit;

  // Start is only looked at in IDLE; in RUN and DONE it is silently dropped.
  assign accept = (state == ST_IDLE) && start &&  round_valid(round_in);
  assign reject = (state == ST_IDLE) && start && !round_valid(round_in);

  // Lane advances on every transfer; slice advances when lane wraps.
  // Clearing on accept makes each run start at (0,0) even if a previous
  // run was cut short by reset.
  add_rc_mod_counter #(.N(LANES), .W(LANE_W)) u_lane_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (en),
    .count (lane),
    .co    (lane_co)
  );

  add_rc_mod_counter #(.N(DEPTH), .W(SLICE_W)) u_slice_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (en & lane_co),
    .count (slice),
    .co    (slice_co)
  );

  // Output decode. en follows ready combinationally so a stalled downstream
  // never loses a bit; the carry/apply flags depend only on state and the
  // counters so they stay stable through a stall.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    en       = 1'b0;
    co_c25   = 1'b0;
    co_c64   = 1'b0;
    apply_rc = 1'b0;
    if (state == ST_RUN) begin
      en       = ready;
      co_c25   = lane_co;
      co_c64   = slice_co;
      apply_rc = (lane == '0);
    end
  end

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign last_bit = en & lane_co & slice_co;

  // Control FSM: state, latched round index and the registered err pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      round <= '0;
      err   <= 1'b0;
    end else begin
      err <= reject;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_RUN;
            round <= round_in;
          end
        end
        ST_RUN: begin
          // Both counters wrap to 0 on this same edge.
          if (last_bit) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_rc_controller.sv
// ---------------------------------------------------------------------------
// tb_add_rc_controller
//   Self-checking bench for add_rc_controller. A behavioural model tracks the
//   run as a flat bit index k (0..1599) with lane = k % 25, slice = k / 25,
//   and every clock cycle all outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_add_rc_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] round_in;
  logic       ready;
  logic       en;
  logic [4:0] lane;
  logic [5:0] slice;
  logic       co_c25;
  logic       co_c64;
  logic       apply_rc;
  logic [4:0] round;
  logic       busy;
  logic       done;
  logic       err;

  add_rc_controller dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .round_in (round_in),
    .ready    (ready),
    .en       (en),
    .lane     (lane),
    .slice    (slice),
    .co_c25   (co_c25),
    .co_c64   (co_c64),
    .apply_rc (apply_rc),
    .round    (round),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    else
      n_pass++;
  endtask

  // ---------------- reference model ----------------
  localparam int NBITS = 25 * 64;
  int         m_mode;   // 0 idle, 1 run, 2 done
  int         m_k;
  logic [4:0] m_round;
  logic       m_err;

  task automatic model_reset();
    m_mode  = 0;
    m_k     = 0;
    m_round = '0;
    m_err   = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic [4:0] r, input logic rd);
    case (m_mode)
      0: begin
        m_err = s && (r >= 5'd24);
        if (s && r < 5'd24) begin
          m_round = r;
          m_mode  = 1;
          m_k     = 0;
        end
      end
      1: begin
        m_err = 1'b0;
        if (rd) begin
          if (m_k == NBITS - 1) begin
            m_mode = 2;
            m_k    = 0;
          end else begin
            m_k++;
          end
        end
      end
      default: begin
        m_err  = 1'b0;
        m_mode = 0;
      end
    endcase
  endtask

  function automatic logic [22:0] model_out(input logic rd);
    logic run;
    int   ln;
    int   sl;
    run = (m_mode == 1);
    ln  = m_k % 25;
    sl  = m_k / 25;
    return {run && rd, 5'(ln), 6'(sl), run && ln == 24, run && sl == 63,
            run && ln == 0, m_round, m_mode != 0, m_mode == 2, m_err};
  endfunction

  function automatic logic [22:0] dut_out();
    return {en, lane, slice, co_c25, co_c64, apply_rc, round, busy, done, err};
  endfunction

  // ---------------- per-run statistics ----------------
  int cyc, en_cnt, c25_cnt, c64_cnt, rc_cnt, done_cnt, done_at;

  task automatic clear_stats();
    cyc = 0; en_cnt = 0; c25_cnt = 0; c64_cnt = 0; rc_cnt = 0;
    done_cnt = 0; done_at = 0;
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, then advance
  // the model at the rising edge. Called just after a rising edge.
  task automatic tick(input logic s, input logic [4:0] r, input logic rd);
    start    = s;
    round_in = r;
    ready    = rd;
    @(negedge clk);
    check("cycle", 32'(dut_out()), 32'(model_out(rd)));
    cyc++;
    if (en)             en_cnt++;
    if (en && co_c25)   c25_cnt++;
    if (en && co_c64)   c64_cnt++;
    if (en && apply_rc) rc_cnt++;
    if (done) begin
      done_cnt++;
      if (done_at == 0) done_at = cyc;
    end
    @(posedge clk);
    model_step(s, r, rd);
    #1;
  endtask

  // rmode: 0 ready high, 1 ready toggling 1/0, 2 random ready + random starts.
  task automatic run_round(input logic [4:0] r, input int rmode, input bit mid_start,
                           input int exp_cycles, input string tag);
    logic       rd;
    logic       s;
    logic [4:0] rr;
    clear_stats();
    tick(1'b1, r, 1'b1);
    for (int i = 0; i < 5000 && m_mode != 0; i++) begin
      case (rmode)
        0:       rd = 1'b1;
        1:       rd = ~i[0];
        default: rd = ($urandom_range(0, 3) != 0);
      endcase
      s  = 1'b0;
      rr = 5'd0;
      if (mid_start && m_mode == 1 && m_k == 5 * 25 + 10) begin
        s  = 1'b1;
        rr = 5'd3;
      end
      if (rmode == 2 && $urandom_range(0, 15) == 0) begin
        s  = 1'b1;
        rr = 5'($urandom_range(0, 31));
      end
      tick(s, rr, rd);
    end
    tick(1'b0, 5'd0, 1'b0);
    check({tag, "_en_count"},    en_cnt,   NBITS);
    check({tag, "_co_c25_count"}, c25_cnt, 64);
    check({tag, "_co_c64_count"}, c64_cnt, 25);
    check({tag, "_apply_rc_count"}, rc_cnt, 64);
    check({tag, "_done_count"},  done_cnt, 1);
    if (exp_cycles != 0)
      check({tag, "_done_cycle"}, done_at, exp_cycles);
  endtask

  // ---------------- table of start requests from IDLE ----------------
  typedef struct {
    logic [4:0] round_in;
    logic       exp_err;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{5'd24, 1'b1, 1'b0};
    vecs[1] = '{5'd31, 1'b1, 1'b0};
    vecs[2] = '{5'd25, 1'b1, 1'b0};
    vecs[3] = '{5'd23, 1'b0, 1'b1};
    vecs[4] = '{5'd0,  1'b0, 1'b1};
    vecs[5] = '{5'd12, 1'b0, 1'b1};

    rst = 1'b0; start = 1'b0; round_in = '0; ready = 1'b0;
    model_reset();
    #3;
    check("reset_outputs", 32'(dut_out()), 32'd0);
    #9 rst = 1'b1;                 // released between edges
    @(posedge clk); #1;
    clear_stats();

    // Table-driven starts: rejected ones must pulse err and stay idle;
    // accepted ones are aborted by an asynchronous reset.
    foreach (vecs[i]) begin
      tick(1'b1, vecs[i].round_in, 1'b1);
      #2;
      check("tbl_err",  32'(err),  32'(vecs[i].exp_err));
      check("tbl_busy", 32'(busy), 32'(vecs[i].exp_busy));
      if (vecs[i].exp_busy) begin
        check("tbl_round", 32'(round), 32'(vecs[i].round_in));
        rst = 1'b0;
        #1;
        check("tbl_abort", 32'(dut_out()), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
      end else begin
        tick(1'b0, 5'd0, 1'b1);
      end
    end
    check("reject_no_en", en_cnt, 0);

    // Full round with ready held high.
    run_round(5'd3, 0, 1'b0, 1602, "full");

    // Ready toggling every cycle.
    run_round(5'd0, 1, 1'b0, 3201, "toggle");

    // Second start mid-run must be ignored.
    run_round(5'd9, 0, 1'b1, 1602, "mid_start");

    // Start in the DONE cycle is ignored, the following IDLE cycle accepts.
    clear_stats();
    tick(1'b1, 5'd4, 1'b1);
    for (int i = 0; i < 2000 && m_mode != 2; i++) tick(1'b0, 5'd0, 1'b1);
    tick(1'b1, 5'd6, 1'b1);        // DONE cycle: dropped
    check("done_start_idle", 32'(m_mode), 32'd0);
    tick(1'b1, 5'd6, 1'b1);        // IDLE: accepted
    #2;
    check("idle_after_done_accept", 32'(busy), 32'd1);
    check("idle_after_done_round",  32'(round), 32'd6);
    for (int i = 0; i < 2000 && m_mode != 0; i++) tick(1'b0, 5'd0, 1'b1);

    // Asynchronous reset at slice 40.
    clear_stats();
    tick(1'b1, 5'd5, 1'b1);
    for (int i = 0; i < 2000 && !(m_mode == 1 && m_k == 40 * 25 + 3); i++)
      tick(1'b0, 5'd0, 1'b1);
    check("pre_rst_slice", 32'(slice), 32'd40);
    ready = 1'b1;
    rst = 1'b0;
    #1;
    check("async_rst_outputs", 32'(dut_out()), 32'd0);
    model_reset();
    @(posedge clk); #1;
    check("rst_no_done", done_cnt, 0);
    rst = 1'b1;
    run_round(5'd7, 0, 1'b0, 1602, "after_rst");

    // Randomised runs against the model.
    for (int n = 0; n < 2; n++)
      run_round(5'($urandom_range(0, 23)), 2, 1'b0, 0, "random");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/add_rc_controller.md
Name: add_rc_controller

Overview:
- Sequencer for the serial add-round-constant (addRc) stage of the encoder datapath.
- On a start pulse it walks the 25-lane × 64-slice state one bit per cycle: lane counter inner, slice counter outer.
- It drives the stage enable and the lane/slice addresses, flags the bit that receives the round-constant XOR, and exposes the counter carry-outs (co_c25, co_c64) that downstream logic and the file-dump monitor key on.
- Downstream back-pressure is honoured through a ready input.

Parameters:
- LANES, 25, lane count per slice; inner counter modulus.
- DEPTH, 64, slice count; outer counter modulus.
- ROUNDS, 24, number of valid round indices.
- RW, 5, width of round index.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to process one round.
- round_in  input  RW  round index, sampled with start.
- ready  input  1  downstream can accept a bit this cycle.
- en  output  1  a bit transfer occurs this cycle; addRc datapath and monitor advance.
- lane  output  5  current lane index, 0..LANES-1.
- slice  output  6  current slice index, 0..DEPTH-1.
- co_c25  output  1  lane == LANES-1 while in RUN.
- co_c64  output  1  slice == DEPTH-1 while in RUN.
- apply_rc  output  1  lane == 0 while in RUN; datapath XORs rc[round][slice] into this bit.
- round  output  RW  latched round index for the RC ROM.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse after the final bit.
- err  output  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (rst=0, async):
  - State IDLE.
  - lane=0, slice=0, round=0.
  - en, busy, done, err, co_c25, co_c64, apply_rc all 0.
- States IDLE, RUN, DONE.
- IDLE:
  - start=1 with round_in<ROUNDS: latch round, clear counters, go to RUN next edge.
  - start=1 with round_in>=ROUNDS: err=1 for one cycle, remain IDLE, round unchanged.
- RUN:
  - en = ready (combinational). First possible en is the cycle after start is accepted.
  - en=1: lane increments. At lane==LANES-1, lane wraps to 0 and slice increments.
  - ready=0: counters and outputs hold; en=0. Stall length is unbounded.
  - en & co_c25 & co_c64: last bit; next state DONE, counters wrap to 0.
- DONE:
  - done=1, busy=1, en=0 for exactly one cycle, then IDLE.
- start in RUN or DONE is ignored: no err, no restart.
- co_c25, co_c64 and apply_rc are decoded from the counters, gated by state==RUN, and are independent of ready.
- Throughput: LANES×DEPTH = 1600 en cycles per round. With ready held high, start to done pulse = 1602 cycles.
- Reset asserted mid-RUN aborts immediately to IDLE with all outputs at reset values. No done pulse.
- start in the same cycle as DONE is ignored. A start in the following IDLE cycle is accepted.
- Counter widths: 5 and 6 bits. Moduli come from the parameters, not from the natural widths.

Decomposition:
- Package add_rc_pkg: LANES, DEPTH, ROUNDS, RW, the state enum (IDLE/RUN/DONE) and the lane/slice width constants.
- Sub-module add_rc_mod_counter, instantiated twice (N=25 and N=64):
  - Parameterised modulus N.
  - Inputs clk, rst, clr, inc.
  - Outputs count and co (count==N-1).

Test Plan:
- Reset then start, round_in=3, ready=1 -> en high for 1600 consecutive cycles starting the cycle after start.
  - co_c25 high every 25th en.
  - co_c64 high for the last 25 en.
  - done pulses at cycle 1602; round=3 throughout.
- ready toggled 1/0 every cycle, round_in=0 -> exactly 1600 en cycles.
  - lane/slice hold while ready=0.
  - done after the final en, total ≈3201 cycles.
- start with round_in=24 and then round_in=31 -> err pulse each time, busy stays 0, no en.
- Second start issued at lane=10, slice=5 mid-RUN -> ignored; the run completes normally with 1600 en.
- rst pulled low at slice=40 -> all outputs 0 asynchronously (before the next clk edge). After release, a new start(round_in=7) runs a full 1600-bit pass.
- apply_rc check -> high exactly when lane==0: 64 times per round, once per slice, coincident with en.
